// File: rtl/rou_table_loader_pkg.sv
// Shared FHE constants, loader state encoding and table geometry helpers
// for the root-of-unity table loader.
package rou_table_loader_pkg;

    localparam int unsigned FHE_MAX_LEN = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned calc_addr_w(input int unsigned max_len);
        return $clog2(max_len);
    endfunction

    // One extra code beyond the ROU stages selects the IROU table.
    function automatic int unsigned calc_sel_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

    localparam int unsigned FHE_STAGES = calc_addr_w(FHE_MAX_LEN);

    // ROU stage s holds 2^s twiddles; the IROU table holds a full MAX_LEN.
    function automatic int unsigned table_depth(input int unsigned tbl,
                                                input int unsigned stages,
                                                input int unsigned max_len);
        return (tbl < stages) ? (32'd1 << tbl) : max_len;
    endfunction

endpackage

// File: rtl/rou_table_loader.sv
// Streams twiddle words into the per-stage ROU tables and the IROU table
// through one registered write port shared by all tables.
module rou_table_loader
    import rou_table_loader_pkg::*;
#(
    parameter int unsigned MAX_LEN = FHE_MAX_LEN,
    parameter int unsigned STAGES  = $clog2(MAX_LEN),
    parameter int unsigned DATA_W  = 64,
    localparam int unsigned ADDR_W = calc_addr_w(MAX_LEN),
    localparam int unsigned SEL_W  = calc_sel_w(STAGES)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_start,
    input  logic              cfg_all,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic              cfg_abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [STAGES-1:0] rou_we,
    output logic              irou_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_din,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q;
    logic [SEL_W-1:0]  tbl_q;
    logic [ADDR_W-1:0] addr_q;
    logic              all_q;

    logic              accept;
    logic              last_entry;
    logic              tbl_is_irou;

    assign s_ready     = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD);
    assign done        = (state_q == ST_DONE);
    assign accept      = s_valid && (state_q == ST_LOAD);
    assign tbl_is_irou = (tbl_q == SEL_W'(STAGES));
    assign last_entry  = (addr_q == ADDR_W'(table_depth(32'(tbl_q), STAGES, MAX_LEN) - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            tbl_q   <= '0;
            addr_q  <= '0;
            all_q   <= 1'b0;
            rou_we  <= '0;
            irou_we <= 1'b0;
            wr_addr <= '0;
            wr_din  <= '0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;

            // Write stage sees the table/address as they were when the word was accepted.
            for (int unsigned s = 0; s < STAGES; s++) begin
                rou_we[s] <= accept && (tbl_q == SEL_W'(s));
            end
            irou_we <= accept && tbl_is_irou;
            if (accept) begin
                wr_addr <= addr_q;
                wr_din  <= s_data;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_all) begin
                            state_q <= ST_LOAD;
                            tbl_q   <= '0;
                            addr_q  <= '0;
                            all_q   <= 1'b1;
                        end else if (cfg_sel <= SEL_W'(STAGES)) begin
                            state_q <= ST_LOAD;
                            tbl_q   <= cfg_sel;
                            addr_q  <= '0;
                            all_q   <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cfg_abort) begin
                        state_q <= ST_IDLE;
                        tbl_q   <= '0;
                        addr_q  <= '0;
                        err     <= 1'b1;
                    end else if (accept) begin
                        if (last_entry) begin
                            addr_q <= '0;
                            if (all_q && !tbl_is_irou) begin
                                tbl_q <= tbl_q + SEL_W'(1);
                            end else begin
                                tbl_q   <= '0;
                                state_q <= ST_DONE;
                            end
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rou_table_loader.sv
// Directed self-checking bench for rou_table_loader at default geometry
// (MAX_LEN 2048, 11 ROU stages plus IROU).
module tb_rou_table_loader;

    localparam int MAX_LEN = 2048;
    localparam int STAGES  = 11;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 11;
    localparam int SEL_W   = 4;
    localparam int OBS_W   = STAGES + 1 + ADDR_W + DATA_W + 4;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cfg_start;
    logic              cfg_all;
    logic [SEL_W-1:0]  cfg_sel;
    logic              cfg_abort;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [STAGES-1:0] rou_we;
    logic              irou_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_din;
    logic              busy;
    logic              done;
    logic              err;

    logic [OBS_W-1:0]  obs;
    logic [OBS_W-1:0]  e;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_din;
    int                n_checks = 0;
    int                n_fail   = 0;

    assign obs = {rou_we, irou_we, wr_addr, wr_din, s_ready, busy, done, err};

    rou_table_loader #(
        .MAX_LEN(MAX_LEN),
        .STAGES (STAGES),
        .DATA_W (DATA_W)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .cfg_start(cfg_start),
        .cfg_all  (cfg_all),
        .cfg_sel  (cfg_sel),
        .cfg_abort(cfg_abort),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .rou_we   (rou_we),
        .irou_we  (irou_we),
        .wr_addr  (wr_addr),
        .wr_din   (wr_din),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // Expected output vector; st == STAGES means IROU, we=0 means no write.
    function automatic logic [OBS_W-1:0] ev(input int st, input logic we,
                                            input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d,
                                            input logic bz, input logic dn,
                                            input logic er);
        logic [STAGES-1:0] r;
        logic              ir;
        r  = '0;
        ir = 1'b0;
        if (we && st < STAGES) r[st] = 1'b1;
        if (we && st == STAGES) ir = 1'b1;
        return {r, ir, a, d, bz, bz, dn, er};
    endfunction

    function automatic int floor_log2(input int v);
        int r;
        r = 0;
        while ((2 << r) <= v) r++;
        return r;
    endfunction

    task automatic start(input logic all, input logic [SEL_W-1:0] sel);
        cfg_all   = all;
        cfg_sel   = sel;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_all   = 1'b0;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        #2;
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", obs, {OBS_W{1'b0}});
        end
        tick();
        tick();
        #3 areset = 1'b0;
        tick();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h expected %h", obs, {OBS_W{1'b0}});
        end
        exp_addr = '0;
        exp_din  = '0;
    endtask

    task automatic test_all_mode;
        int st;
        int a;
        start(1'b1, '0);
        e = ev(0, 1'b0, exp_addr, exp_din, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL all_enter_load: got %h expected %h", obs, e);
        end
        s_valid = 1'b1;
        for (int k = 0; k < 2 * MAX_LEN - 1; k++) begin
            s_data = DATA_W'(k);
            tick();
            if (k < MAX_LEN - 1) begin
                st = floor_log2(k + 1);
                a  = k + 1 - (1 << st);
            end else begin
                st = STAGES;
                a  = k - (MAX_LEN - 1);
            end
            exp_addr = ADDR_W'(a);
            exp_din  = DATA_W'(k);
            e = ev(st, 1'b1, exp_addr, exp_din, k < 2 * MAX_LEN - 2, k == 2 * MAX_LEN - 2, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL all_word_%0d: got %h expected %h", k, obs, e);
            end
        end
        s_valid = 1'b0;
        tick();
        e = ev(0, 1'b0, 11'd2047, 64'd4094, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL all_idle_hold: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_single_irou;
        int   w;
        int   cyc;
        logic v;
        start(1'b0, 4'd11);
        w   = 0;
        cyc = 0;
        while (w < MAX_LEN && cyc < 10000) begin
            v       = ($urandom_range(0, 3) != 0);
            s_valid = v;
            s_data  = 64'hDEAD_BEEF_0000_0000 | DATA_W'(w);
            tick();
            cyc++;
            if (v) begin
                exp_addr = ADDR_W'(w);
                exp_din  = s_data;
                e = ev(STAGES, 1'b1, exp_addr, exp_din, w < MAX_LEN - 1, w == MAX_LEN - 1, 1'b0);
                w++;
            end else begin
                e = ev(STAGES, 1'b0, exp_addr, exp_din, 1'b1, 1'b0, 1'b0);
            end
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL irou_cycle_%0d: got %h expected %h", cyc, obs, e);
            end
        end
        n_checks++;
        if (w != MAX_LEN) begin
            n_fail++;
            $display("FAIL irou_timeout: got %0d words expected %0d", w, MAX_LEN);
        end
        s_valid = 1'b0;
        tick();
        e = ev(0, 1'b0, exp_addr, exp_din, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL irou_idle_after: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_bad_sel;
        logic [SEL_W-1:0] sels [2];
        sels[0] = 4'd13;
        sels[1] = 4'd12;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            start(1'b0, sels[i]);
            e = ev(0, 1'b0, exp_addr, exp_din, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bad_sel_%0d_err: got %h expected %h", sels[i], obs, e);
            end
            tick();
            e = ev(0, 1'b0, exp_addr, exp_din, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bad_sel_%0d_after: got %h expected %h", sels[i], obs, e);
            end
            s_valid = 1'b0;
        end
    endtask

    task automatic test_abort;
        start(1'b0, 4'd10);
        s_valid = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            s_data    = 64'h1000 + DATA_W'(k);
            cfg_abort = (k == 100);
            tick();
            exp_addr = ADDR_W'(k);
            exp_din  = s_data;
            e = ev(10, 1'b1, exp_addr, exp_din, k < 100, 1'b0, k == 100);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL abort_word_%0d: got %h expected %h", k, obs, e);
            end
        end
        cfg_abort = 1'b0;
        s_valid   = 1'b0;
        tick();
        e = ev(0, 1'b0, exp_addr, exp_din, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_idle: got %h expected %h", obs, e);
        end
        // Restart must begin again at address 0.
        start(1'b0, 4'd10);
        s_valid = 1'b1;
        s_data  = 64'h2000;
        tick();
        exp_addr = '0;
        exp_din  = 64'h2000;
        e = ev(10, 1'b1, exp_addr, exp_din, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_restart_addr0: got %h expected %h", obs, e);
        end
        s_valid   = 1'b0;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        e = ev(0, 1'b0, exp_addr, exp_din, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_no_word: got %h expected %h", obs, e);
        end
        // Abort beats the stage-0 advance to DONE.
        start(1'b0, 4'd0);
        s_valid   = 1'b1;
        s_data    = 64'h3000;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        s_valid   = 1'b0;
        exp_addr  = '0;
        exp_din   = 64'h3000;
        e = ev(0, 1'b1, exp_addr, exp_din, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_vs_advance: got %h expected %h", obs, e);
        end
        tick();
        e = ev(0, 1'b0, exp_addr, exp_din, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_vs_advance_nodone: got %h expected %h", obs, e);
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_in_idle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_reset_mid_load;
        start(1'b0, 4'd7);
        s_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            s_data = 64'h7000 + DATA_W'(k);
            tick();
            exp_addr = ADDR_W'(k);
            exp_din  = s_data;
            e = ev(7, 1'b1, exp_addr, exp_din, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rst_stage7_word_%0d: got %h expected %h", k, obs, e);
            end
        end
        s_data = 64'h7000 + 64'd50;
        #3 areset = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_load: got %h expected %h", obs, {OBS_W{1'b0}});
        end
        tick();
        #3 areset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            s_data = 64'h7100 + DATA_W'(k);
            tick();
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL rst_no_restart_%0d: got %h expected %h", k, obs, {OBS_W{1'b0}});
            end
        end
        s_valid  = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
    endtask

    task automatic test_start_while_busy;
        start(1'b0, 4'd2);
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_data    = 64'h200 + DATA_W'(k);
            cfg_start = (k == 1 || k == 2);
            cfg_all   = (k == 1);
            cfg_sel   = (k == 1) ? 4'd13 : 4'd5;
            tick();
            cfg_start = 1'b0;
            cfg_all   = 1'b0;
            exp_addr  = ADDR_W'(k);
            exp_din   = s_data;
            e = ev(2, 1'b1, exp_addr, exp_din, k < 3, k == 3, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL busy_start_word_%0d: got %h expected %h", k, obs, e);
            end
        end
        // Now in DONE: start and abort must both be ignored.
        cfg_start = 1'b1;
        cfg_all   = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_all   = 1'b0;
        cfg_abort = 1'b0;
        e = ev(0, 1'b0, exp_addr, exp_din, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL done_ignores_cfg: got %h expected %h", obs, e);
        end
        tick();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL done_start_not_latched: got %h expected %h", obs, e);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        cfg_start = 1'b0;
        cfg_all   = 1'b0;
        cfg_sel   = '0;
        cfg_abort = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        exp_addr  = '0;
        exp_din   = '0;
        e         = '0;
        test_reset();
        test_all_mode();
        test_single_irou();
        test_bad_sel();
        test_abort();
        test_reset_mid_load();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rou_table_loader.md
ROU_TABLE_LOADER -- requirements
Module: rou_table_loader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 2048, meaning the maximum polynomial length (power of two, >= 4).
REQ-002 SHALL have parameter STAGES, default $clog2(MAX_LEN), meaning the number of forward NTT stages and the number of ROU tables.
REQ-003 SHALL have parameter DATA_W, default 64, meaning the twiddle word width.
REQ-004 SHALL have derived constant ADDR_W = $clog2(MAX_LEN) and SEL_W = $clog2(STAGES+1).
REQ-005 aclk  input  1  single clock; all logic on its rising edge.
REQ-006 areset  input  1  asynchronous, active-high reset.
REQ-007 cfg_start  input  1  one-cycle load request.
REQ-008 cfg_all  input  1  1 = load stages 0..STAGES-1 then IROU; 0 = load only table cfg_sel.
REQ-009 cfg_sel  input  SEL_W  target table: 0..STAGES-1 = ROU stage s, STAGES = IROU.
REQ-010 cfg_abort  input  1  one-cycle abort request.
REQ-011 s_valid / s_ready / s_data  input / output / input  1 / 1 / DATA_W  twiddle word stream.
REQ-012 rou_we  output  STAGES  one-hot write enable, bit s = ROU stage s.
REQ-013 irou_we  output  1  IROU table write enable.
REQ-014 wr_addr / wr_din  output  ADDR_W / DATA_W  shared write address and data for all tables.
REQ-015 busy  output  1  high while in LOAD state.
REQ-016 done / err  output  1 / 1  one-cycle completion pulse / one-cycle error pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD, DONE.
REQ-018 Table depth SHALL be 2^s for ROU stage s and MAX_LEN for IROU.
REQ-019 In IDLE, cfg_start with cfg_all=1 SHALL enter LOAD with current table = stage 0 and addr counter = 0.
REQ-020 In IDLE, cfg_start with cfg_all=0 and cfg_sel <= STAGES SHALL enter LOAD with current table = cfg_sel and addr counter = 0.
REQ-021 In IDLE, cfg_start with cfg_all=0 and cfg_sel > STAGES SHALL pulse err the next cycle and remain in IDLE.
REQ-022 cfg_start while in LOAD or DONE SHALL be ignored; no err pulse.
REQ-023 s_ready SHALL equal (state == LOAD), driven combinationally from the state register.
REQ-024 A word accepted (s_valid & s_ready) at cycle t SHALL produce exactly one write at cycle t+1: the enable of the current table = 1, wr_addr = addr counter, wr_din = s_data. All enables SHALL be 0 in cycles with no accepted word.
REQ-025 The addr counter SHALL increment per accepted word. When the last entry is accepted (addr = depth-1), the counter SHALL wrap to 0 and the table SHALL advance.
REQ-026 Table advance: in all-mode, stage s SHALL go to s+1, stage STAGES-1 SHALL go to IROU, and IROU SHALL go to DONE. In single mode, the table SHALL go to DONE.
REQ-027 Stage 0 (depth 1) SHALL advance after a single word.
REQ-028 DONE SHALL last exactly one cycle, assert done, and return to IDLE. busy SHALL be low in DONE.
REQ-029 cfg_abort in LOAD SHALL return to IDLE the next cycle. A word accepted in the same cycle SHALL still be written at t+1. No done pulse; err SHALL pulse once.
REQ-030 cfg_abort in IDLE or DONE SHALL have no effect. cfg_abort SHALL have priority over table advance in the same cycle.
REQ-031 wr_addr/wr_din SHALL hold their last value when no write occurs.
REQ-032 Full all-mode load SHALL accept exactly (MAX_LEN-1) + MAX_LEN words (4095 at default).

Reset
REQ-033 areset SHALL asynchronously force state to IDLE and the counter and table to 0. rou_we, irou_we, wr_addr, wr_din, busy, done, and err SHALL all be 0. s_ready SHALL be 0.
REQ-034 Reset asserted mid-LOAD SHALL drop any pending write. After release, the block SHALL require a new cfg_start.

Structure
REQ-035 The state enum, SEL_W/ADDR_W derivation and a depth function (table index -> depth) SHALL live in the shared FHE package alongside MAX_LEN.
REQ-036 No sub-module; a single module with one registered write stage.
REQ-037 Integration SHALL fan rou_we[s]/wr_addr/wr_din into rou_wr_port[s] and irou_we into irou_wr_port.

Verification
REQ-038 All-mode, s_valid held 1, data = index 0..4094 -> rou_we[0] once at addr 0 data 0. rou_we[1] at addr 0,1 with data 1,2. IROU at addr 0..2047 with data 2047..4094. done once, 4096 cycles after cfg_start.
REQ-039 Single mode cfg_sel=11 (IROU), random s_valid gaps -> exactly 2048 irou_we pulses with consecutive addr. No rou_we pulse. done once.
REQ-040 cfg_all=0, cfg_sel=13 -> err pulse one cycle later. busy stays 0 and s_ready stays 0.
REQ-041 cfg_abort after 100 words of stage 10, coincident with an accepted word -> 101st write occurs. err pulses, IDLE next cycle, no done. A new cfg_start restarts at addr 0.
REQ-042 areset asserted at word 50 of stage 7 -> all outputs 0 within the reset cycle. A subsequent stream without cfg_start produces no writes (s_ready=0).
REQ-043 cfg_start pulsed while busy -> ignored: table and counter sequence unchanged and no err.
